// File: rtl/actor_move_scheduler.sv
// Round-robin grid movement sequencer for Pac-Man and ghosts, checking walls in a single-port maze memory.
// Optional GHOST_COLLISION_EN macro builds the Pac-Man/ghost collision detector; otherwise collision is tied low.
module actor_move_scheduler #(
    parameter int NUM_ACTORS = 4,
    parameter int TICK_CYCLES = 1000000,
    parameter int RD_LATENCY = 1,
    parameter logic [10*NUM_ACTORS-1:0] START_BLOCKS = {10'd368, 10'd367, 10'd366, 10'd720}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [4*NUM_ACTORS-1:0]  dir,
    output logic [9:0]               wall_addr,
    output logic                     wall_rd,
    input  logic                     wall_data,
    output logic [10*NUM_ACTORS-1:0] positions,
    output logic                     busy,
    output logic                     round_done,
    output logic                     collision
);

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam int IDX_W = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, READ, WAIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [9:0]       cand;
    logic [1:0]       wait_cnt;
    logic             pending;
    logic [9:0]       pos [NUM_ACTORS];

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = enable && (tick_cnt == CNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    logic [3:0] cur_dir;
    logic [9:0] cur_pos;
    logic [4:0] row;
    logic [4:0] col;
    logic       move_ok;
    logic [9:0] move_to;
    logic       last_actor;

    // NOTE: every variable assigned here gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        cur_dir    = dir[4*int'(idx) +: 4];
        cur_pos    = pos[idx];
        row        = cur_pos[9:5];
        col        = cur_pos[4:0];
        move_ok    = 1'b1;
        move_to    = cur_pos;
        last_actor = (idx == IDX_W'(NUM_ACTORS - 1));
        if (cur_dir[3]) begin
            move_ok = (row != 5'd0);
            move_to = cur_pos - 10'd32;
        end else if (cur_dir[2]) begin
            move_ok = (row != 5'd31);
            move_to = cur_pos + 10'd32;
        end else if (cur_dir[1]) begin
            move_to = {row, col - 5'd1};   // column wraps through the side tunnel
        end else if (cur_dir[0]) begin
            move_to = {row, col + 5'd1};
        end else begin
            move_ok = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cand       <= '0;
            wait_cnt   <= '0;
            pending    <= 1'b0;
            wall_addr  <= '0;
            wall_rd    <= 1'b0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            // NOTE: the position file is a handful of registers, so it is reset explicitly to the start blocks.
            for (int a = 0; a < NUM_ACTORS; a++) begin
                pos[a] <= START_BLOCKS[10*a +: 10];
            end
        end else begin
            // A tick landing while pending is already set is dropped.
            if (state == IDLE && pending) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (pending) begin
                        state <= SELECT;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (move_ok) begin
                        cand      <= move_to;
                        wall_addr <= move_to;
                        wall_rd   <= 1'b1;
                        state     <= READ;
                    end else if (last_actor) begin
                        round_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                READ: begin
                    wall_rd  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 2'(RD_LATENCY - 1)) begin
                        if (!wall_data) begin
                            pos[idx] <= cand;
                        end
                        if (last_actor) begin
                            round_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SELECT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    round_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar a = 0; a < NUM_ACTORS; a++) begin : g_pos
        assign positions[10*a +: 10] = pos[a];
    end

`ifdef GHOST_COLLISION_EN
    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int g = 1; g < NUM_ACTORS; g++) begin
            if (pos[g] == pos[0]) hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
        end else if (state == DONE) begin
            collision <= hit;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule
